// File: rtl/alu_pkg.sv
// Shared types for the alu32 byte-serial command front end.
package alu_pkg;

  typedef enum logic [1:0] {
    OpNop      = 2'd0,
    OpAdd      = 2'd1,
    OpMultiply = 2'd2,
    OpDivide   = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_A,
    S_RX_B,
    S_ISSUE,
    S_WAIT,
    S_TX
  } state_e;

  localparam int OperandBytes = 4;
  localparam int FrameBytes   = 9;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command front end for alu32: RX frame assembly, ALU handshake, TX result serialization.
// Optional DIV_ZERO_GUARD_EN: divide by zero is answered locally (q=all ones, r=A) without an ALU issue.
//
// state   | meaning
// S_IDLE  | waiting for opcode byte
// S_RX_A  | shifting in operand A, LSB first
// S_RX_B  | shifting in operand B, LSB first
// S_ISSUE | presenting command to alu32
// S_WAIT  | waiting for alu32 result
// S_TX    | sending result bytes, LSB first
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int RxTimeout = 1000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  output logic [1:0]  alu_opcode_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  input  logic [63:0] alu_result_i,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int TimerW = (RxTimeout > 1) ? $clog2(RxTimeout) : 1;
  localparam int TimerLoadInt = (RxTimeout > 0) ? RxTimeout - 1 : 0;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(TimerLoadInt);
  localparam logic [2:0] LastOperandByte = 3'(OperandBytes - 1);

  state_e            state_q, state_d;
  opcode_e           opcode_q, opcode_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [63:0]       result_q, result_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_q, err_d;

  logic rx_fire;
  logic [2:0] last_tx_byte;

  assign rx_ready_o      = (state_q == S_IDLE) || (state_q == S_RX_A) || (state_q == S_RX_B);
  assign tx_valid_o      = (state_q == S_TX);
  assign alu_valid_o     = (state_q == S_ISSUE);
  assign alu_ready_o     = (state_q == S_WAIT);
  assign busy_o          = (state_q != S_IDLE);
  assign err_o           = err_q;
  assign tx_data_o       = result_q[7:0];
  assign alu_opcode_o    = opcode_q;
  assign alu_operand_a_o = op_a_q;
  assign alu_operand_b_o = op_b_q;

  assign rx_fire      = rx_valid_i && rx_ready_o;
  assign last_tx_byte = (opcode_q == OpDivide) ? 3'd7 : 3'd3;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire && (rx_data_i != 8'h00)) begin
          if (rx_data_i <= 8'h03) begin
            opcode_d = opcode_e'(rx_data_i[1:0]);
            cnt_d    = 3'd0;
            timer_d  = TimerLoad;
            state_d  = S_RX_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RX_A, S_RX_B: begin
        if (rx_fire) begin
          timer_d = TimerLoad;
          cnt_d   = cnt_q + 3'd1;
          if (state_q == S_RX_A) op_a_d = {rx_data_i, op_a_q[31:8]};
          else                   op_b_d = {rx_data_i, op_b_q[31:8]};
          if (cnt_q == LastOperandByte) begin
            cnt_d = 3'd0;
            if (state_q == S_RX_A) begin
              state_d = S_RX_B;
            end else begin
              state_d = S_ISSUE;
`ifdef DIV_ZERO_GUARD_EN
              if ((opcode_q == OpDivide) && (op_b_d == 32'd0)) begin
                result_d = {op_a_q, 32'hFFFF_FFFF};
                state_d  = S_TX;
              end
`endif
            end
          end
        end else if (RxTimeout != 0) begin
          // Partial frame is dropped so a stale operand never reaches alu32.
          if (timer_q == '0) begin
            err_d   = 1'b1;
            cnt_d   = 3'd0;
            op_a_d  = 32'd0;
            op_b_d  = 32'd0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (alu_ready_i) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (alu_valid_i) begin
          result_d = alu_result_i;
          cnt_d    = 3'd0;
          state_d  = S_TX;
        end
      end

      S_TX: begin
        if (tx_ready_i) begin
          result_d = {8'h00, result_q[63:8]};
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == last_tx_byte) begin
            cnt_d   = 3'd0;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      opcode_q <= OpNop;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      result_q <= 64'd0;
      cnt_q    <= 3'd0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural alu32 stub and a random-ready TX sink.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int Tmo = 20;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic [1:0]  alu_opcode_o;
  logic [31:0] alu_operand_a_o;
  logic [31:0] alu_operand_b_o;
  logic [63:0] alu_result_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic        busy_o;
  logic        err_o;

  alu_cmd_sequencer #(.RxTimeout(Tmo)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_opcode_o(alu_opcode_o),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_result_i(alu_result_i), .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int issue_cnt = 0;
  logic [1:0]  iss_op;
  logic [31:0] iss_a, iss_b;
  logic [7:0]  txq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX sink with randomly toggling ready; byte counted when valid&&ready ahead of the next edge.
  initial begin
    tx_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      tx_ready_i = 1'($urandom_range(0, 1));
      if (reset_ni && tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (err_o) err_cnt++;
  end

  // alu32 stub: accepts a command 3 cycles after valid, returns the result 2 cycles later.
  initial begin
    logic signed [63:0] prod;
    logic signed [31:0] q, r;
    alu_ready_i  = 1'b0;
    alu_valid_i  = 1'b0;
    alu_result_i = 64'd0;
    forever begin
      @(negedge clk_i);
      if (alu_valid_o) begin
        repeat (3) @(negedge clk_i);
        iss_op = alu_opcode_o; iss_a = alu_operand_a_o; iss_b = alu_operand_b_o;
        issue_cnt++;
        alu_ready_i = 1'b1;
        @(negedge clk_i);
        alu_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        case (iss_op)
          2'd1: alu_result_i = {32'd0, iss_a + iss_b};
          2'd2: begin
            prod = $signed(iss_a) * $signed(iss_b);
            alu_result_i = {32'd0, prod[31:0]};
          end
          2'd3: begin
            q = $signed(iss_a) / $signed(iss_b);
            r = $signed(iss_a) % $signed(iss_b);
            alu_result_i = {r, q};
          end
          default: alu_result_i = 64'd0;
        endcase
        alu_valid_i = 1'b1;
        for (int n = 0; n < 50 && !alu_ready_o; n++) @(negedge clk_i);
        @(negedge clk_i);
        alu_valid_i = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check("rx_accept_timeout", 64'(n), 64'd0);
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int nbytes, input logic [63:0] exp,
                           input bit expect_issue);
    int n;
    int issues0;
    logic [63:0] obs;
    issues0 = issue_cnt;
    txq.delete();
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    if (expect_issue) begin
      check({tag, "_issue_valid"}, 64'(alu_valid_o), 64'd1);
      check({tag, "_rx_backpressure"}, 64'(rx_ready_o), 64'd0);
    end
    n = 0;
    while ((txq.size() < nbytes || busy_o) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_done_in_time"}, 64'(n < 2000), 64'd1);
    check({tag, "_busy_clear"}, 64'(busy_o), 64'd0);
    check({tag, "_tx_count"}, 64'(txq.size()), 64'(nbytes));
    obs = 64'd0;
    for (int i = 0; i < txq.size() && i < 8; i++) obs[8*i +: 8] = txq[i];
    check({tag, "_tx_bytes"}, obs, exp);
    check({tag, "_issue_count"}, 64'(issue_cnt - issues0), expect_issue ? 64'd1 : 64'd0);
    if (expect_issue) begin
      check({tag, "_issue_op"}, 64'(iss_op), 64'(op[1:0]));
      check({tag, "_issue_a"}, 64'(iss_a), 64'(a));
      check({tag, "_issue_b"}, 64'(iss_b), 64'(b));
    end
  endtask

  initial begin
    int n;
    int e0, i0;
    reset_ni   = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_rx_ready", 64'(rx_ready_o), 64'd1);
    check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    check("rst_alu_valid", 64'(alu_valid_o), 64'd0);
    check("rst_alu_ready", 64'(alu_ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_tx_data", 64'(tx_data_o), 64'd0);
    check("rst_operands", {alu_operand_a_o, alu_operand_b_o}, 64'd0);
    reset_ni = 1'b1;
    @(negedge clk_i);

    run_frame("add", 8'h01, 32'd5, 32'd7, 4, 64'h0000_0000_0000_000C, 1'b1);
    run_frame("mul", 8'h02, 32'hFFFF_FFFD, 32'd4, 4, 64'h0000_0000_FFFF_FFF4, 1'b1);
    run_frame("div", 8'h03, 32'hFFFF_FFF9, 32'd2, 8, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

    e0 = err_cnt;
    send_byte(8'h00);
    repeat (2) @(negedge clk_i);
    check("nop_busy", 64'(busy_o), 64'd0);
    check("nop_no_err", 64'(err_cnt - e0), 64'd0);

    send_byte(8'h07);
    repeat (2) @(negedge clk_i);
    check("badop_err_once", 64'(err_cnt - e0), 64'd1);
    check("badop_idle", 64'(busy_o), 64'd0);
    run_frame("add_after_bad", 8'h01, 32'd5, 32'd7, 4, 64'h0000_0000_0000_000C, 1'b1);

    e0 = err_cnt;
    i0 = issue_cnt;
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h00);
    n = 0;
    while (!err_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("tmo_cycles", 64'(n), 64'(Tmo));
    @(negedge clk_i);
    check("tmo_idle", 64'(busy_o), 64'd0);
    check("tmo_err_once", 64'(err_cnt - e0), 64'd1);
    check("tmo_no_issue", 64'(issue_cnt - i0), 64'd0);

    // A single idle gap one cycle short of the limit must not abort.
    e0 = err_cnt;
    send_byte(8'h01);
    send_byte(8'h05);
    repeat (Tmo - 2) @(negedge clk_i);
    check("tmo_edge_busy", 64'(busy_o), 64'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h07 : 8'h00);
    n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check("tmo_edge_no_err", 64'(err_cnt - e0), 64'd0);

    send_byte(8'h02);
    send_byte(8'h11);
    #3 reset_ni = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy_o), 64'd0);
    check("async_rst_rx_ready", 64'(rx_ready_o), 64'd1);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    run_frame("mul_after_rst", 8'h02, 32'd6, 32'd7, 4, 64'h0000_0000_0000_002A, 1'b1);

`ifdef DIV_ZERO_GUARD_EN
    run_frame("div0_guard", 8'h03, 32'd10, 32'd0, 8, 64'h0000_000A_FFFF_FFFF, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
